// File: rtl/rs_if.sv
// Dispatcher, result-bus and ALU-dispatch signals of the ALU reservation station.
// master: dispatcher/CDB side, slave: reservation station.
interface rs_if #(
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  issue_valid;
  logic [6:0]            issue_opcode;
  logic [2:0]            issue_funct3;
  logic                  issue_funct7;
  logic [DATA_WIDTH-1:0] issue_val1;
  logic                  issue_q1_busy;
  logic [ROB_WIDTH-1:0]  issue_q1;
  logic [DATA_WIDTH-1:0] issue_val2;
  logic                  issue_q2_busy;
  logic [ROB_WIDTH-1:0]  issue_q2;
  logic [DATA_WIDTH-1:0] issue_imm;
  logic [ROB_WIDTH-1:0]  issue_rob_pos;
  logic [DATA_WIDTH-1:0] issue_pc;
  logic                  rs_full;

  logic                  alu_cdb_valid;
  logic [ROB_WIDTH-1:0]  alu_cdb_rob_pos;
  logic [DATA_WIDTH-1:0] alu_cdb_val;
  logic                  lsb_cdb_valid;
  logic [ROB_WIDTH-1:0]  lsb_cdb_rob_pos;
  logic [DATA_WIDTH-1:0] lsb_cdb_val;

  logic                  alu_en;
  logic [6:0]            alu_opcode;
  logic [2:0]            alu_funct3;
  logic                  alu_funct7;
  logic [DATA_WIDTH-1:0] alu_val1;
  logic [DATA_WIDTH-1:0] alu_val2;
  logic [DATA_WIDTH-1:0] alu_imm;
  logic [ROB_WIDTH-1:0]  alu_rob_pos;
  logic [DATA_WIDTH-1:0] alu_pc;

  modport master (
    output issue_valid, issue_opcode, issue_funct3, issue_funct7, issue_val1, issue_q1_busy,
           issue_q1, issue_val2, issue_q2_busy, issue_q2, issue_imm, issue_rob_pos, issue_pc,
           alu_cdb_valid, alu_cdb_rob_pos, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob_pos,
           lsb_cdb_val,
    input  rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm,
           alu_rob_pos, alu_pc
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_funct3, issue_funct7, issue_val1, issue_q1_busy,
           issue_q1, issue_val2, issue_q2_busy, issue_q2, issue_imm, issue_rob_pos, issue_pc,
           alu_cdb_valid, alu_cdb_rob_pos, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob_pos,
           lsb_cdb_val,
    output rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm,
           alu_rob_pos, alu_pc
  );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: operand capture from two CDBs, lowest-index ready dispatch.
// Define RS_CDB_BYPASS_EN to let same-cycle CDB results make an entry ready for select.
module reservation_station #(
  parameter int unsigned RS_SIZE    = 16,
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  input logic  rdy,
  input logic  rollback,
  rs_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]    busy_q;
  logic [6:0]            opcode_q  [RS_SIZE];
  logic [2:0]            funct3_q  [RS_SIZE];
  logic                  funct7_q  [RS_SIZE];
  logic [DATA_WIDTH-1:0] val1_q    [RS_SIZE];
  logic                  q1_busy_q [RS_SIZE];
  logic [ROB_WIDTH-1:0]  q1_q      [RS_SIZE];
  logic [DATA_WIDTH-1:0] val2_q    [RS_SIZE];
  logic                  q2_busy_q [RS_SIZE];
  logic [ROB_WIDTH-1:0]  q2_q      [RS_SIZE];
  logic [DATA_WIDTH-1:0] imm_q     [RS_SIZE];
  logic [ROB_WIDTH-1:0]  rob_pos_q [RS_SIZE];
  logic [DATA_WIDTH-1:0] pc_q      [RS_SIZE];

  logic                  alu_en_q;
  logic [6:0]            alu_opcode_q;
  logic [2:0]            alu_funct3_q;
  logic                  alu_funct7_q;
  logic [DATA_WIDTH-1:0] alu_val1_q;
  logic [DATA_WIDTH-1:0] alu_val2_q;
  logic [DATA_WIDTH-1:0] alu_imm_q;
  logic [ROB_WIDTH-1:0]  alu_rob_pos_q;
  logic [DATA_WIDTH-1:0] alu_pc_q;

  logic [RS_SIZE-1:0]    q1_alu_hit, q1_lsb_hit, q2_alu_hit, q2_lsb_hit;
  logic [RS_SIZE-1:0]    cand;
  logic                  win_found;
  logic [IdxW-1:0]       win_idx;
  logic [DATA_WIDTH-1:0] win_val1, win_val2;
  logic                  free_found;
  logic [IdxW-1:0]       free_idx;

  logic                  ins_q1_busy, ins_q2_busy;
  logic [DATA_WIDTH-1:0] ins_val1, ins_val2;

  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      q1_alu_hit[i] = bus.alu_cdb_valid && (bus.alu_cdb_rob_pos == q1_q[i]);
      q1_lsb_hit[i] = bus.lsb_cdb_valid && (bus.lsb_cdb_rob_pos == q1_q[i]);
      q2_alu_hit[i] = bus.alu_cdb_valid && (bus.alu_cdb_rob_pos == q2_q[i]);
      q2_lsb_hit[i] = bus.lsb_cdb_valid && (bus.lsb_cdb_rob_pos == q2_q[i]);
`ifdef RS_CDB_BYPASS_EN
      cand[i] = busy_q[i] && (!q1_busy_q[i] || q1_alu_hit[i] || q1_lsb_hit[i]) &&
                (!q2_busy_q[i] || q2_alu_hit[i] || q2_lsb_hit[i]);
`else
      cand[i] = busy_q[i] && !q1_busy_q[i] && !q2_busy_q[i];
`endif
    end
  end

  // Priority encoders: scan downwards so the lowest index is left standing.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(i);
      end
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    win_val1 = val1_q[win_idx];
    win_val2 = val2_q[win_idx];
`ifdef RS_CDB_BYPASS_EN
    if (q1_busy_q[win_idx]) begin
      win_val1 = q1_alu_hit[win_idx] ? bus.alu_cdb_val : bus.lsb_cdb_val;
    end
    if (q2_busy_q[win_idx]) begin
      win_val2 = q2_alu_hit[win_idx] ? bus.alu_cdb_val : bus.lsb_cdb_val;
    end
`endif
  end

  // Insert-time forwarding; ALU bus wins if both match.
  always_comb begin
    ins_q1_busy = bus.issue_q1_busy;
    ins_val1    = bus.issue_val1;
    ins_q2_busy = bus.issue_q2_busy;
    ins_val2    = bus.issue_val2;
    if (bus.issue_q1_busy) begin
      if (bus.alu_cdb_valid && bus.alu_cdb_rob_pos == bus.issue_q1) begin
        ins_q1_busy = 1'b0;
        ins_val1    = bus.alu_cdb_val;
      end else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_pos == bus.issue_q1) begin
        ins_q1_busy = 1'b0;
        ins_val1    = bus.lsb_cdb_val;
      end
    end
    if (bus.issue_q2_busy) begin
      if (bus.alu_cdb_valid && bus.alu_cdb_rob_pos == bus.issue_q2) begin
        ins_q2_busy = 1'b0;
        ins_val2    = bus.alu_cdb_val;
      end else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_pos == bus.issue_q2) begin
        ins_q2_busy = 1'b0;
        ins_val2    = bus.lsb_cdb_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= '0;
      alu_en_q      <= 1'b0;
      alu_opcode_q  <= '0;
      alu_funct3_q  <= '0;
      alu_funct7_q  <= 1'b0;
      alu_val1_q    <= '0;
      alu_val2_q    <= '0;
      alu_imm_q     <= '0;
      alu_rob_pos_q <= '0;
      alu_pc_q      <= '0;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        opcode_q[i]  <= '0;
        funct3_q[i]  <= '0;
        funct7_q[i]  <= 1'b0;
        val1_q[i]    <= '0;
        q1_busy_q[i] <= 1'b0;
        q1_q[i]      <= '0;
        val2_q[i]    <= '0;
        q2_busy_q[i] <= 1'b0;
        q2_q[i]      <= '0;
        imm_q[i]     <= '0;
        rob_pos_q[i] <= '0;
        pc_q[i]      <= '0;
      end
    end else if (rdy) begin
      if (rollback) begin
        busy_q   <= '0;
        alu_en_q <= 1'b0;
      end else begin
        alu_en_q <= win_found;
        if (win_found) begin
          alu_opcode_q  <= opcode_q[win_idx];
          alu_funct3_q  <= funct3_q[win_idx];
          alu_funct7_q  <= funct7_q[win_idx];
          alu_val1_q    <= win_val1;
          alu_val2_q    <= win_val2;
          alu_imm_q     <= imm_q[win_idx];
          alu_rob_pos_q <= rob_pos_q[win_idx];
          alu_pc_q      <= pc_q[win_idx];
          busy_q[win_idx] <= 1'b0;
        end
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (busy_q[i] && q1_busy_q[i] && (q1_alu_hit[i] || q1_lsb_hit[i])) begin
            q1_busy_q[i] <= 1'b0;
            val1_q[i]    <= q1_alu_hit[i] ? bus.alu_cdb_val : bus.lsb_cdb_val;
          end
          if (busy_q[i] && q2_busy_q[i] && (q2_alu_hit[i] || q2_lsb_hit[i])) begin
            q2_busy_q[i] <= 1'b0;
            val2_q[i]    <= q2_alu_hit[i] ? bus.alu_cdb_val : bus.lsb_cdb_val;
          end
        end
        // Free slot comes from pre-edge busy bits, so it never collides with the winner.
        if (bus.issue_valid && free_found) begin
          busy_q[free_idx]    <= 1'b1;
          opcode_q[free_idx]  <= bus.issue_opcode;
          funct3_q[free_idx]  <= bus.issue_funct3;
          funct7_q[free_idx]  <= bus.issue_funct7;
          val1_q[free_idx]    <= ins_val1;
          q1_busy_q[free_idx] <= ins_q1_busy;
          q1_q[free_idx]      <= bus.issue_q1;
          val2_q[free_idx]    <= ins_val2;
          q2_busy_q[free_idx] <= ins_q2_busy;
          q2_q[free_idx]      <= bus.issue_q2;
          imm_q[free_idx]     <= bus.issue_imm;
          rob_pos_q[free_idx] <= bus.issue_rob_pos;
          pc_q[free_idx]      <= bus.issue_pc;
        end
      end
    end
  end

  assign bus.rs_full     = &busy_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_funct3  = alu_funct3_q;
  assign bus.alu_funct7  = alu_funct7_q;
  assign bus.alu_val1    = alu_val1_q;
  assign bus.alu_val2    = alu_val2_q;
  assign bus.alu_imm     = alu_imm_q;
  assign bus.alu_rob_pos = alu_rob_pos_q;
  assign bus.alu_pc      = alu_pc_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station; follows RS_CDB_BYPASS_EN if defined.
module tb_reservation_station;
  localparam logic [6:0] OpAddi = 7'b0010011;
  localparam logic [6:0] OpAdd  = 7'b0110011;

  logic clk = 1'b0;
  logic rst, rdy, rollback;
  int   tests = 0;
  int   fails = 0;

  rs_if #(.ROB_WIDTH(4), .DATA_WIDTH(32)) bus ();

  reservation_station #(.RS_SIZE(16), .ROB_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_bus();
    bus.issue_valid = 1'b0; bus.issue_opcode = '0; bus.issue_funct3 = '0;
    bus.issue_funct7 = 1'b0; bus.issue_val1 = '0; bus.issue_q1_busy = 1'b0;
    bus.issue_q1 = '0; bus.issue_val2 = '0; bus.issue_q2_busy = 1'b0; bus.issue_q2 = '0;
    bus.issue_imm = '0; bus.issue_rob_pos = '0; bus.issue_pc = '0;
    bus.alu_cdb_valid = 1'b0; bus.alu_cdb_rob_pos = '0; bus.alu_cdb_val = '0;
    bus.lsb_cdb_valid = 1'b0; bus.lsb_cdb_rob_pos = '0; bus.lsb_cdb_val = '0;
  endtask

  // Called just after a negedge: presents one instruction for the following posedge.
  task automatic issue(input logic [6:0] op, input logic [31:0] v1, input logic q1b,
                       input logic [3:0] q1, input logic [31:0] v2, input logic q2b,
                       input logic [3:0] q2, input logic [31:0] imm, input logic [3:0] rob);
    bus.issue_valid = 1'b1; bus.issue_opcode = op; bus.issue_funct3 = 3'b000;
    bus.issue_funct7 = 1'b0; bus.issue_val1 = v1; bus.issue_q1_busy = q1b; bus.issue_q1 = q1;
    bus.issue_val2 = v2; bus.issue_q2_busy = q2b; bus.issue_q2 = q2; bus.issue_imm = imm;
    bus.issue_rob_pos = rob; bus.issue_pc = 32'h1000 + 32'(rob) * 4;
    @(negedge clk);
    clear_bus();
  endtask

  task automatic alu_bcast(input logic [3:0] tag, input logic [31:0] val);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob_pos = tag; bus.alu_cdb_val = val;
    @(negedge clk);
    clear_bus();
  endtask

  task automatic test_reset();
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL reset_alu_en got %b want 0", bus.alu_en); end
    tests++; if (bus.rs_full !== 1'b0) begin fails++; $display("FAIL reset_rs_full got %b want 0", bus.rs_full); end
    tests++; if (bus.alu_val1 !== 32'h0 || bus.alu_rob_pos !== 4'h0 || bus.alu_pc !== 32'h0) begin
      fails++; $display("FAIL reset_alu_data got val1=%h rob=%h pc=%h want 0", bus.alu_val1, bus.alu_rob_pos, bus.alu_pc);
    end
  endtask

  task automatic test_ready_insert();
    issue(OpAddi, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd3, 4'd2);
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL ready_early got alu_en=%b want 0", bus.alu_en); end
    @(negedge clk);
    tests++;
    if (bus.alu_en !== 1'b1 || bus.alu_val1 !== 32'd5 || bus.alu_imm !== 32'd3 || bus.alu_rob_pos !== 4'd2
        || bus.alu_opcode !== OpAddi || bus.alu_pc !== 32'h1008) begin
      fails++; $display("FAIL ready_dispatch got en=%b val1=%h imm=%h rob=%h op=%b pc=%h want 1/5/3/2/0010011/1008",
                        bus.alu_en, bus.alu_val1, bus.alu_imm, bus.alu_rob_pos, bus.alu_opcode, bus.alu_pc);
    end
    @(negedge clk);
    tests++;
    if (bus.alu_en !== 1'b0 || bus.alu_val1 !== 32'd5) begin
      fails++; $display("FAIL ready_freed_hold got en=%b val1=%h want 0/5", bus.alu_en, bus.alu_val1);
    end
  endtask

  task automatic test_wakeup();
    issue(OpAdd, 32'd0, 1'b1, 4'd7, 32'h20, 1'b0, 4'd0, 32'd0, 4'd4);
    alu_bcast(4'd6, 32'hDEAD);
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL wake_wrong_tag got alu_en=%b want 0", bus.alu_en); end
    alu_bcast(4'd7, 32'h10);
`ifndef RS_CDB_BYPASS_EN
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL wake_capture_cycle got alu_en=%b want 0", bus.alu_en); end
    @(negedge clk);
`endif
    tests++;
    if (bus.alu_en !== 1'b1 || bus.alu_val1 !== 32'h10 || bus.alu_val2 !== 32'h20 || bus.alu_rob_pos !== 4'd4) begin
      fails++; $display("FAIL wake_dispatch got en=%b val1=%h val2=%h rob=%h want 1/10/20/4",
                        bus.alu_en, bus.alu_val1, bus.alu_val2, bus.alu_rob_pos);
    end
    @(negedge clk);
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL wake_single got alu_en=%b want 0", bus.alu_en); end
  endtask

  task automatic test_insert_forward();
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob_pos = 4'd3; bus.lsb_cdb_val = 32'hABCD;
    issue(OpAdd, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'd0, 4'd9);
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL fwd_early got alu_en=%b want 0", bus.alu_en); end
    @(negedge clk);
    tests++;
    if (bus.alu_en !== 1'b1 || bus.alu_val2 !== 32'hABCD || bus.alu_val1 !== 32'd1 || bus.alu_rob_pos !== 4'd9) begin
      fails++; $display("FAIL fwd_dispatch got en=%b val1=%h val2=%h rob=%h want 1/1/abcd/9",
                        bus.alu_en, bus.alu_val1, bus.alu_val2, bus.alu_rob_pos);
    end
    @(negedge clk);
  endtask

  task automatic test_full_priority();
    int waited;
    for (int i = 0; i < 16; i++) begin
      issue(OpAdd, 32'd0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 32'd0, 4'(i));
    end
    tests++; if (bus.rs_full !== 1'b1) begin fails++; $display("FAIL full_set got rs_full=%b want 1", bus.rs_full); end
    issue(OpAddi, 32'h55, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd15);
    tests++;
    if (bus.rs_full !== 1'b1 || bus.alu_en !== 1'b0) begin
      fails++; $display("FAIL full_drop got rs_full=%b alu_en=%b want 1/0", bus.rs_full, bus.alu_en);
    end
    alu_bcast(4'd9, 32'h77);
    waited = 0;
    while (bus.alu_en !== 1'b1 && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (bus.alu_en !== 1'b1 || bus.alu_rob_pos !== 4'(k) || bus.alu_val1 !== 32'h77 || bus.alu_val2 !== 32'(k)) begin
        fails++; $display("FAIL full_order[%0d] got en=%b rob=%h val1=%h val2=%h want 1/%h/77/%h",
                          k, bus.alu_en, bus.alu_rob_pos, bus.alu_val1, bus.alu_val2, k, k);
      end
      if (k == 0) begin
        tests++; if (bus.rs_full !== 1'b0) begin fails++; $display("FAIL full_drop_after_dispatch got rs_full=%b want 0", bus.rs_full); end
      end
      @(negedge clk);
    end
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL full_no_extra got alu_en=%b want 0", bus.alu_en); end
  endtask

  task automatic test_rollback();
    int seen;
    for (int i = 0; i < 5; i++) begin
      issue(OpAdd, 32'd0, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
    end
    rollback = 1'b1;
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob_pos = 4'd11; bus.alu_cdb_val = 32'h99;
    issue(OpAddi, 32'h8, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd8);
    rollback = 1'b0;
    tests++;
    if (bus.alu_en !== 1'b0 || bus.rs_full !== 1'b0) begin
      fails++; $display("FAIL rollback_clear got alu_en=%b rs_full=%b want 0/0", bus.alu_en, bus.rs_full);
    end
    alu_bcast(4'd11, 32'h99);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.alu_en === 1'b1) seen++;
      @(negedge clk);
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rollback_no_dispatch got %0d dispatches want 0", seen); end
  endtask

  task automatic test_rdy();
    rdy = 1'b0;
    issue(OpAddi, 32'h6, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd6);
    rdy = 1'b1;
    @(negedge clk); @(negedge clk);
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL rdy_insert_frozen got alu_en=%b want 0", bus.alu_en); end
    issue(OpAddi, 32'h5A, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd5);
    rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL rdy_dispatch_frozen got alu_en=%b want 0", bus.alu_en); end
    rdy = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.alu_en !== 1'b1 || bus.alu_rob_pos !== 4'd5 || bus.alu_val1 !== 32'h5A) begin
      fails++; $display("FAIL rdy_resume got en=%b rob=%h val1=%h want 1/5/5a", bus.alu_en, bus.alu_rob_pos, bus.alu_val1);
    end
    rdy = 1'b0;
    @(negedge clk);
    tests++; if (bus.alu_en !== 1'b1) begin fails++; $display("FAIL rdy_hold_en got alu_en=%b want 1", bus.alu_en); end
    rdy = 1'b1;
    @(negedge clk);
    tests++; if (bus.alu_en !== 1'b0) begin fails++; $display("FAIL rdy_after got alu_en=%b want 0", bus.alu_en); end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(OpAddi, 32'h11, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd1);
    issue(OpAddi, 32'h33, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd3);
    tests++;
    if (bus.alu_en !== 1'b1 || bus.alu_rob_pos !== 4'd1) begin
      fails++; $display("FAIL rstmid_pre got en=%b rob=%h want 1/1", bus.alu_en, bus.alu_rob_pos);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.alu_en !== 1'b0 || bus.rs_full !== 1'b0 || bus.alu_val1 !== 32'h0) begin
      fails++; $display("FAIL rstmid_async got en=%b full=%b val1=%h want 0/0/0", bus.alu_en, bus.rs_full, bus.alu_val1);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.alu_en === 1'b1) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rstmid_no_dispatch got %0d dispatches want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    clear_bus();
    @(negedge clk); @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_ready_insert();
    test_wakeup();
    test_insert_forward();
    test_full_priority();
    test_rollback();
    test_rdy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
